// File: rtl/ncl_sched_pkg.sv
// Shared types and helpers for the NCL stage scheduler.
package ncl_sched_pkg;
  localparam int IDX_W  = 3;  // grant index width, covers up to 8 requesters
  localparam int HOLD_W = 4;  // stage reset hold counter width
  localparam int WAIT_W = 8;  // wait-state watchdog counter width

  typedef enum logic [2:0] {HOLD, IDLE, DATA, WAIT_DATA, NULL, WAIT_NULL, ACK} state_t;

  // First set request at or after ptr, wrapping modulo n.
  function automatic logic [IDX_W-1:0] rr_pick(input logic [7:0] req,
                                               input logic [IDX_W-1:0] ptr,
                                               input int n);
    logic [IDX_W-1:0] idx;
    rr_pick = ptr;
    for (int i = 7; i >= 0; i--) begin
      if (i < n) begin
        idx = IDX_W'((int'(ptr) + i) % n);
        if (req[idx]) rr_pick = idx;
      end
    end
  endfunction
endpackage

// File: rtl/ncl_sync2.sv
// Two-flop synchronizer, async reset to 0.
module ncl_sync2 (
  input  logic clk,
  input  logic rst,
  input  logic d,
  output logic q
);
  logic meta;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      meta <= 1'b0;
      q    <= 1'b0;
    end else begin
      meta <= d;
      q    <= meta;
    end
  end
endmodule

// File: rtl/ncl_stage_sched.sv
// Round-robin scheduler driving one shared dual-rail NCL stage through DATA/NULL cycles.
// Optional wait-state watchdog with sticky err output: define NCL_SCHED_TIMEOUT_EN.
module ncl_stage_sched
  import ncl_sched_pkg::*;
#(
  parameter int N_REQ    = 4,
  parameter int WIDTH    = 8,
  parameter int RSB_HOLD = 4
`ifdef NCL_SCHED_TIMEOUT_EN
  , parameter int TIMEOUT = 255
`endif
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [N_REQ-1:0]       req,
  input  logic [N_REQ*WIDTH-1:0] req_data,
  output logic [N_REQ-1:0]       ack,
  output logic [WIDTH-1:0]       resp_data,
  output logic                   busy,
  output logic [WIDTH-1:0]       rail1,
  output logic [WIDTH-1:0]       rail0,
  output logic                   stage_rsb,
  input  logic                   stage_done,
  input  logic [WIDTH-1:0]       stage_out1
`ifdef NCL_SCHED_TIMEOUT_EN
  , output logic                 err
`endif
);
  state_t             state;
  logic [IDX_W-1:0]   g, ptr, pick, next_ptr;
  logic [WIDTH-1:0]   data, result, pick_data;
  logic [HOLD_W-1:0]  hold_cnt;
  logic [7:0]         req_ext;
  logic               done_s;

  ncl_sync2 u_sync (.clk(clk), .rst(rst), .d(stage_done), .q(done_s));

  always_comb begin
    req_ext = '0;
    req_ext[N_REQ-1:0] = req;
    pick = rr_pick(req_ext, ptr, N_REQ);
    pick_data = '0;
    for (int i = 0; i < N_REQ; i++)
      if (pick == IDX_W'(i)) pick_data = req_data[i*WIDTH +: WIDTH];
    next_ptr = (g == IDX_W'(N_REQ-1)) ? '0 : g + 1'b1;
  end

  always_comb begin
    ack = '0;
    for (int i = 0; i < N_REQ; i++)
      ack[i] = (state == ACK) && (g == IDX_W'(i));
  end

  assign busy = (state != HOLD) && (state != IDLE);

`ifdef NCL_SCHED_TIMEOUT_EN
  logic [WAIT_W-1:0] wait_cnt;
  logic              timeout_hit;

  assign timeout_hit = ((state == WAIT_DATA && !done_s) || (state == WAIT_NULL && done_s)) &&
                       (wait_cnt == WAIT_W'(TIMEOUT-1));

  // Cleared in the cycle before each wait state is entered.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)                                     wait_cnt <= '0;
    else if (state == DATA || state == NULL)     wait_cnt <= '0;
    else if (state == WAIT_DATA || state == WAIT_NULL) wait_cnt <= wait_cnt + 1'b1;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst)              err <= 1'b0;
    else if (timeout_hit) err <= 1'b1;
  end
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= HOLD;
      stage_rsb <= 1'b0;
      rail1     <= '0;
      rail0     <= '0;
      resp_data <= '0;
      result    <= '0;
      data      <= '0;
      g         <= '0;
      ptr       <= '0;
      hold_cnt  <= '0;
    end else begin
`ifdef NCL_SCHED_TIMEOUT_EN
      // Abandon the grant: re-reset the stage and skip past the stuck requester.
      if (timeout_hit) begin
        state     <= HOLD;
        stage_rsb <= 1'b0;
        rail1     <= '0;
        rail0     <= '0;
        hold_cnt  <= '0;
        ptr       <= next_ptr;
      end else
`endif
      case (state)
        HOLD: begin
          if (hold_cnt == HOLD_W'(RSB_HOLD-1)) begin
            hold_cnt  <= '0;
            stage_rsb <= 1'b1;
            state     <= IDLE;
          end else begin
            hold_cnt <= hold_cnt + 1'b1;
          end
        end
        IDLE: begin
          // A stage still showing DATA must drain before a new wavefront.
          if (|req && !done_s) begin
            g     <= pick;
            data  <= pick_data;
            state <= DATA;
          end
        end
        DATA: begin
          rail1 <= data;
          rail0 <= ~data;
          state <= WAIT_DATA;
        end
        WAIT_DATA: begin
          if (done_s) begin
            result <= stage_out1;
            state  <= NULL;
          end
        end
        NULL: begin
          rail1 <= '0;
          rail0 <= '0;
          state <= WAIT_NULL;
        end
        WAIT_NULL: begin
          if (!done_s) begin
            resp_data <= result;
            state     <= ACK;
          end
        end
        ACK: begin
          ptr   <= next_ptr;
          state <= IDLE;
        end
        default: state <= HOLD;
      endcase
    end
  end
endmodule

// File: tb/tb_ncl_stage_sched.sv
// Self-checking bench for ncl_stage_sched with a behavioural NCL stage and scoreboard.
// Timeout scenario runs when NCL_SCHED_TIMEOUT_EN is defined.
module tb_ncl_stage_sched;
  localparam int N   = 4;
  localparam int W   = 8;
  localparam int RSB = 4;

  logic           clk, rst;
  logic [N-1:0]   req;
  logic [N*W-1:0] req_data;
  logic [N-1:0]   ack;
  logic [W-1:0]   resp_data, rail1, rail0, stage_out1;
  logic           busy, stage_rsb, stage_done;
`ifdef NCL_SCHED_TIMEOUT_EN
  logic           err;
`endif

  ncl_stage_sched #(.N_REQ(N), .WIDTH(W), .RSB_HOLD(RSB)
`ifdef NCL_SCHED_TIMEOUT_EN
    , .TIMEOUT(20)
`endif
  ) dut (
    .clk(clk), .rst(rst), .req(req), .req_data(req_data), .ack(ack),
    .resp_data(resp_data), .busy(busy), .rail1(rail1), .rail0(rail0),
    .stage_rsb(stage_rsb), .stage_done(stage_done), .stage_out1(stage_out1)
`ifdef NCL_SCHED_TIMEOUT_EN
    , .err(err)
`endif
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  int n_cmp = 0;
  int n_bad = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  function automatic int rr_model(input logic [N-1:0] r, input int p);
    for (int k = 0; k < N; k++)
      if (r[(p + k) % N]) return (p + k) % N;
    return -1;
  endfunction

  // Behavioural stage: goes full when every bit has a rail high, empty when all rails low,
  // with a three-cycle propagation delay; can be forced full or stuck empty.
  bit         force_full, stuck_empty;
  logic [2:0] dq;
  logic [W-1:0] vq [3];
  logic       st_full;
  logic [W-1:0] st_val;
  initial begin
    stage_done = 1'b0; stage_out1 = '0; st_full = 1'b0; st_val = '0; dq = '0;
    for (int i = 0; i < 3; i++) vq[i] = '0;
    forever begin
      @(posedge clk); #1;
      if (!stage_rsb) st_full = 1'b0;
      else if (&(rail1 | rail0)) begin st_full = 1'b1; st_val = rail1; end
      else if ((rail1 | rail0) == '0) st_full = 1'b0;
      dq = {dq[1:0], st_full};
      vq[2] = vq[1]; vq[1] = vq[0]; vq[0] = st_val;
      stage_done = force_full ? 1'b1 : (stuck_empty ? 1'b0 : dq[2]);
      stage_out1 = vq[2];
    end
  end

  // Scoreboard: checks every cycle on the falling edge.
  int           ptr_m, cur_w, since_rel;
  logic [W-1:0] exp_d, resp_exp, inv_d;
  logic [N-1:0] req_prev, one_hot;
  logic [N*W-1:0] rd_prev;
  bit           busy_prev, err_prev;
  initial begin
    ptr_m = 0; cur_w = -1; since_rel = 0; exp_d = '0; resp_exp = '0;
    req_prev = '0; rd_prev = '0; busy_prev = 0; err_prev = 0;
  end

  always @(negedge clk) begin
    if (rst) begin
      chk("rst_rails", {rail1, rail0}, 0);
      chk("rst_ack", ack, 0);
      chk("rst_rsb", stage_rsb, 0);
      chk("rst_busy", busy, 0);
      chk("rst_resp", resp_data, 0);
      ptr_m = 0; cur_w = -1; since_rel = 0; resp_exp = '0; busy_prev = 0; err_prev = 0;
    end else begin
`ifdef NCL_SCHED_TIMEOUT_EN
      if (err && !err_prev) begin
        if (cur_w < 0) chk("err_without_grant", 1, 0);
        else ptr_m = (cur_w + 1) % N;
        cur_w = -1; since_rel = 0;
      end
      err_prev = err;
`endif
      chk("rsb_hold", stage_rsb, (since_rel >= RSB) ? 1 : 0);
      if (since_rel < 1000) since_rel++;
      if (busy && !busy_prev) begin
        cur_w = rr_model(req_prev, ptr_m);
        if (cur_w < 0) chk("grant_without_req", 1, 0);
        else exp_d = rd_prev[cur_w*W +: W];
      end
      chk("rail_excl", rail1 & rail0, 0);
      if ((rail1 | rail0) != '0) begin
        if (cur_w < 0) chk("rails_without_grant", {rail1, rail0}, 0);
        else begin
          inv_d = ~exp_d;
          chk("rail1", rail1, exp_d);
          chk("rail0", rail0, inv_d);
        end
        chk("busy_rails", busy, 1);
      end
      if (ack != '0) begin
        if (cur_w < 0) chk("spurious_ack", ack, 0);
        else begin
          one_hot = '0;
          one_hot[cur_w] = 1'b1;
          chk("ack_vec", ack, one_hot);
          resp_exp = exp_d;
          ptr_m = (cur_w + 1) % N;
          cur_w = -1;
        end
      end
      chk("resp_data", resp_data, resp_exp);
      if (!stage_rsb) begin
        chk("hold_busy", busy, 0);
        chk("hold_rails", {rail1, rail0}, 0);
      end
      busy_prev = busy;
      req_prev = req;
      rd_prev = req_data;
    end
  end

  task automatic tick;
    @(posedge clk); #1;
  endtask

  task automatic wait_ack(input int budget, output int idx, output logic [N-1:0] av);
    idx = -1; av = '0;
    for (int c = 0; c < budget; c++) begin
      tick();
      if (ack != '0) begin
        av = ack;
        for (int i = 0; i < N; i++) if (ack[i]) idx = i;
        return;
      end
    end
    chk("ack_timeout", 0, 1);
  endtask

  task automatic wait_rails(input int budget);
    for (int c = 0; c < budget; c++) begin
      tick();
      if ((rail1 | rail0) != '0) return;
    end
    chk("rails_timeout", 0, 1);
  endtask

  int           idx, order [5];
  logic [N-1:0] av, r;
  logic [W-1:0] lit [4];

  initial begin
    order = '{0, 1, 2, 3, 0};
    lit = '{8'h11, 8'h22, 8'h33, 8'h44};
    rst = 1'b1; req = '0; req_data = '0; force_full = 0; stuck_empty = 0;
    repeat (3) tick();

    // Reset release: rsb low for exactly RSB edges, stage left NULL.
    rst = 1'b0;
    for (int k = 0; k < 6; k++) begin
      tick();
      chk("rel_rsb", stage_rsb, (k >= 3) ? 1 : 0);
      chk("rel_busy", busy, 0);
      chk("rel_rails", {rail1, rail0}, 0);
    end

    // Round robin with every requester held.
    req_data = {8'h44, 8'h33, 8'h22, 8'h11};
    req = 4'b1111;
    for (int i = 0; i < 5; i++) begin
      wait_ack(200, idx, av);
      chk("rr_order", idx, order[i]);
      if (idx >= 0) chk("rr_resp", resp_data, lit[idx]);
      if (i == 4) req = '0;
    end
    repeat (3) tick();

    // Single transaction on requester 1.
    req_data = '0;
    req_data[15:8] = 8'hA5;
    req = 4'b0010;
    wait_rails(50);
    chk("single_rail1", rail1, 8'hA5);
    chk("single_rail0", rail0, 8'h5A);
    wait_ack(200, idx, av);
    chk("single_ack", av, 4'b0010);
    chk("single_resp", resp_data, 8'hA5);
    req = '0;
    tick();
    chk("single_ack_pulse", ack, 0);

    // Stage not empty: no grant while the stage reports DATA.
    force_full = 1;
    repeat (4) tick();
    req_data[7:0] = 8'h3C;
    req = 4'b0001;
    for (int k = 0; k < 8; k++) begin
      tick();
      chk("full_busy", busy, 0);
      chk("full_rails", {rail1, rail0}, 0);
    end
    force_full = 0;
    wait_ack(200, idx, av);
    chk("full_ack", idx, 0);
    chk("full_resp", resp_data, 8'h3C);
    req = '0;
    repeat (2) tick();

    // Reset during WAIT_DATA, then the held request is served after the hold.
    req_data[23:16] = 8'hC3;
    req = 4'b0100;
    wait_rails(50);
    tick();
    rst = 1'b1;
    #1;
    chk("midrst_rails", {rail1, rail0}, 0);
    chk("midrst_rsb", stage_rsb, 0);
    chk("midrst_ack", ack, 0);
    repeat (2) tick();
    rst = 1'b0;
    wait_ack(200, idx, av);
    chk("midrst_next_ack", idx, 2);
    chk("midrst_next_resp", resp_data, 8'hC3);
    req = '0;
    repeat (2) tick();

`ifdef NCL_SCHED_TIMEOUT_EN
    // Stage stuck empty after DATA: watchdog fires after 20 wait cycles.
    begin
      int n_wait;
      stuck_empty = 1;
      req_data[15:8] = 8'h96;
      req = 4'b0010;
      wait_rails(50);
      n_wait = 1;
      for (int c = 0; c < 100 && !err; c++) begin
        tick();
        chk("to_no_ack", ack, 0);
        if (!err && (rail1 | rail0) != '0) n_wait++;
      end
      chk("to_cycles", n_wait, 20);
      chk("to_err", err, 1);
      chk("to_rsb", stage_rsb, 0);
      stuck_empty = 0;
      req_data[23:16] = 8'h69;
      req = 4'b0110;
      wait_ack(200, idx, av);
      chk("to_next_grant", idx, 2);
      chk("to_err_sticky", err, 1);
      req = '0;
      repeat (2) tick();
    end
`endif

    // Randomized traffic; requests change only in ack cycles.
    for (int i = 0; i < N; i++) req_data[i*W +: W] = W'($urandom);
    req = N'($urandom_range(1, (1 << N) - 1));
    for (int t = 0; t < 40; t++) begin
      wait_ack(200, idx, av);
      if (idx < 0) break;
      r = req;
      r[idx] = 1'($urandom_range(0, 1));
      if ($urandom_range(0, 2) == 0) r |= N'($urandom);
      if (r == '0) r[$urandom_range(0, N-1)] = 1'b1;
      for (int i = 0; i < N; i++)
        if (!req[i] || i == idx) req_data[i*W +: W] = W'($urandom);
      req = r;
    end
    req = '0;
    repeat (5) tick();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: got no finish, expected finish before time limit");
    n_bad++;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $fatal(1, "watchdog");
  end
endmodule

// File: doc/ncl_stage_sched.md
Name: ncl_stage_sched

Overview:
- Synchronous scheduler sharing one dual-rail NCL pipeline stage (a th22r-based threshold-gate array with completion detection) among N_REQ clocked requesters.
- Round-robin arbitration; each granted transaction is a full four-phase NCL cycle: DATA wavefront, wait for complete, NULL wavefront, wait for empty.
- Drives the stage's active-low gate reset (rsb) and returns the captured stage result to the winning requester.

Parameters:
- N_REQ, 4, number of requesters (2..8)
- WIDTH, 8, logical bits per transaction (2*WIDTH rails)
- RSB_HOLD, 4, cycles rsb stays low after rst deasserts (1..15)
- TIMEOUT, 255, max cycles in any wait state (optional feature only)

Ports:
- clk  in  1  clock
- rst  in  1  asynchronous active-high reset
- req  in  N_REQ  per-requester request, level, held until ack
- req_data  in  N_REQ*WIDTH  requester i data at [i*WIDTH +: WIDTH], stable while req[i]
- ack  out  N_REQ  one-cycle pulse to the granted requester on completion
- resp_data  out  WIDTH  stage result, valid in the ack cycle, held until the next ack
- busy  out  1  high in any state except IDLE and HOLD
- rail1  out  WIDTH  dual-rail true rails to the stage
- rail0  out  WIDTH  dual-rail false rails to the stage
- stage_rsb  out  1  active-low reset to the stage gates
- stage_done  in  1  async completion: 1 = all outputs DATA, 0 = all NULL
- stage_out1  in  WIDTH  stage output true rails, sampled only in WAIT_DATA

Behaviour:
- Reset (rst=1, async): state HOLD, stage_rsb=0, rail1=rail0=0 (NULL), ack=0, resp_data=0, busy=0, rr pointer=0, hold counter=0.
- stage_done passes through a 2-flop synchronizer; done_s is the synchronized value, 2-cycle latency.
- HOLD: counts RSB_HOLD cycles after rst falls, keeping stage_rsb=0; at count end stage_rsb=1 and state goes to IDLE. stage_rsb stays 1 until the next rst.
- IDLE: if any req is set and done_s=0, grant the lowest index at or after the rr pointer (wrapping modulo N_REQ). Latch g and req_data[g]; go to DATA. If done_s=1, stay in IDLE (stage not empty).
- DATA: one cycle. Register rail1=data, rail0=~data (never both 1 on the same bit); go to WAIT_DATA.
- WAIT_DATA: hold rails. When done_s=1, capture stage_out1 into an internal result register and go to NULL.
- NULL: rails=0; go to WAIT_NULL.
- WAIT_NULL: when done_s=0, go to ACK.
- ACK: ack[g]=1 for one cycle, resp_data=result, rr pointer=(g+1) mod N_REQ; go to IDLE.
- Minimum transaction length is 6 cycles plus stage delay plus 2×2 synchronizer cycles.
- Back-to-back: a requester that drops req in the ack cycle and re-raises it loses to any other pending requester.
- req dropping mid-transaction is illegal; the scheduler ignores it and completes the transaction.
- rst mid-transaction: immediate return to HOLD; rails go NULL; ack is never issued for the aborted grant.
- At most one ack bit is set per cycle; ack is never set outside ACK.

Optional Feature:
- Macro NCL_SCHED_TIMEOUT_EN.
- When defined:
  - 8-bit wait counter, cleared on entering WAIT_DATA or WAIT_NULL.
  - If it reaches TIMEOUT: state goes to HOLD (stage_rsb=0 for RSB_HOLD cycles, rails NULL).
  - Sticky output err (1 bit, cleared only by rst) is set; ack is not issued.
  - The rr pointer advances past g.
- When undefined: no counter, no err port; wait states wait indefinitely.

Decomposition:
- Package ncl_sched_pkg:
  - state enum {HOLD, IDLE, DATA, WAIT_DATA, NULL, WAIT_NULL, ACK}
  - counter width constants
  - function rr_pick(req, ptr) returning the grant index
- Sub-module ncl_sync2: 2-flop synchronizer with async reset to 0, used for stage_done.

Test Plan:
- Reset release: rst 1→0, stage_done=0 → stage_rsb low exactly 4 cycles, then high; busy=0; rails 0.
- Single transaction: req[1]=1, req_data[15:8]=8'hA5, stage model echoes with 3-cycle delay → rail1=A5, rail0=5A; ack[1] pulses once; resp_data=A5.
- Round-robin: req=4'b1111 held, ack each → grant order 0,1,2,3,0; no two ack bits high in one cycle.
- Stage not empty: stage_done held 1 in IDLE with req[0]=1 → no DATA issued until stage_done falls, then normal completion.
- Mid-operation reset: assert rst during WAIT_DATA → rails NULL the same cycle, no ack, HOLD sequence repeats, the next request is served normally.
- Timeout (macro on, TIMEOUT=20): stage_done stuck 0 after DATA → after 20 wait cycles err=1, stage_rsb low 4 cycles, ack not issued, the next request goes to g+1.
